// File: rtl/mul_share_pkg.sv
// Shared definitions for the mul_share_arbiter slice.
//   NREQ  - number of requesters sharing the multiplier
//   OP_W  - operand width per requester
//   RES_W - full-width product width
//   state_t - arbiter FSM encoding (IDLE, MUL, RESP)
package mul_share_pkg;

  localparam int NREQ  = 4;
  localparam int OP_W  = 16;
  localparam int RES_W = 32;
  localparam int PTR_W = 2;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mul_core.sv
// Registered 16x16 unsigned multiplier with LAT register stages.
//   clk, reset : clock, asynchronous active-high reset
//   start      : one-cycle pulse; a/b are sampled on this cycle
//   a, b       : unsigned operands
//   product    : full-width product, valid while done is high
//   done       : one-cycle pulse LAT cycles after start
// Stage 1 is the operand register; stages 2..LAT pipeline the product.
module mul_core
  import mul_share_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [RES_W-1:0] product,
  output logic             done
);

  logic [OP_W-1:0]  a_q, a_d;
  logic [OP_W-1:0]  b_q, b_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [RES_W-1:0] prod0;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    if (start) begin
      a_d = a;
      b_d = b;
    end
    vld_d = (vld_q << 1) | LAT'(start);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      vld_q <= vld_d;
    end
  end

  assign prod0 = RES_W'(a_q) * RES_W'(b_q);
  assign done  = vld_q[LAT-1];

  generate
    if (LAT == 1) begin : g_single
      assign product = prod0;
    end else begin : g_pipe
      logic [RES_W-1:0] pipe_q [LAT-1];
      logic [RES_W-1:0] pipe_d [LAT-1];

      always_comb begin
        pipe_d[0] = prod0;
        for (int i = 1; i < LAT - 1; i++) pipe_d[i] = pipe_q[i-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LAT - 1; i++) pipe_q[i] <= '0;
        end else begin
          for (int i = 0; i < LAT - 1; i++) pipe_q[i] <= pipe_d[i];
        end
      end

      assign product = pipe_q[LAT-2];
    end
  endgenerate

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters.
//   clk, reset  : clock, asynchronous active-high reset
//   req_valid   : per-requester operand valid
//   req_ready   : per-requester accept (at most one bit, only in IDLE)
//   req_a/req_b : packed operands, requester i at [16i+15:16i]
//   rsp_valid   : one-hot result valid to the owning requester (RESP only)
//   rsp_ready   : per-requester result accept; only the owner's bit counts
//   rsp_payload : product in RESP, 0 otherwise
//   dbg_state   : current FSM state
// Handshakes: a transfer happens on a cycle where valid and ready of the
// same index are both high; ready never waits on anything but valid here,
// and a raised rsp_valid holds with a stable payload until it is taken.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [RES_W-1:0]     rsp_payload,
  output state_t               dbg_state
);

  // Returns {found, index}: first valid bit at or above ptr, wrapping.
  // Walking k downward lets the smallest offset overwrite the result last.
  function automatic logic [PTR_W:0] rr_pick(input logic [NREQ-1:0]  valid,
                                             input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] idx;
    rr_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + PTR_W'(k);
      if (valid[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] gnt_q, gnt_d;
  logic [RES_W-1:0] prod_q, prod_d;

  logic [PTR_W:0]   pick;
  logic [PTR_W-1:0] pick_idx;
  logic             mul_start;
  logic [OP_W-1:0]  sel_a, sel_b;
  logic [RES_W-1:0] core_product;
  logic             core_done;

  assign pick     = rr_pick(req_valid, ptr_q);
  assign pick_idx = pick[PTR_W-1:0];
  assign sel_a    = req_a[OP_W*pick_idx +: OP_W];
  assign sel_b    = req_b[OP_W*pick_idx +: OP_W];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    prod_d      = prod_q;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_payload = '0;
    mul_start   = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is raised only on a requester that is already valid, so a
        // raised ready is always a completed handshake this cycle.
        if (pick[PTR_W]) begin
          req_ready = NREQ'(1) << pick_idx;
          mul_start = 1'b1;
          gnt_d     = pick_idx;
          ptr_d     = pick_idx + PTR_W'(1);
          cnt_d     = CNT_W'(LAT);
          state_d   = MUL;
        end
      end
      MUL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (core_done) prod_d = core_product;
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        rsp_valid   = NREQ'(1) << gnt_q;
        rsp_payload = prod_q;
        if (rsp_ready[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      prod_q  <= prod_d;
    end
  end

  assign dbg_state = state_q;

  mul_core #(.LAT(LAT)) u_mul_core (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (sel_a),
    .b       (sel_b),
    .product (core_product),
    .done    (core_done)
  );

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed scenarios plus random traffic,
// checked every cycle against a timestamp-based reference model.
module tb_mul_share_arbiter;
  import mul_share_pkg::*;

  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b;
  logic [31:0] rsp_payload;
  state_t      dbg_state;

  always #5 clk = ~clk;

  mul_share_arbiter #(.LAT(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_payload (rsp_payload),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [31:0] exp_q[$];
  int          acc_idx[$];
  int          acc_cyc[$];

  bit          m_busy  = 0;
  int          m_owner = 0;
  int          m_due   = 0;
  int          m_ptr   = 0;
  logic [31:0] m_prod  = '0;

  logic [3:0]  obs_rv;
  logic [31:0] obs_pl;
  int          obs_cyc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] v);
    for (int k = 0; k < 4; k++)
      if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  // One cycle: inputs are already set; sample after settling, compare with
  // the model, advance the model from this cycle's inputs, move to next cycle.
  task automatic tick();
    int          g;
    logic [3:0]  er, ev;
    logic [31:0] ep, a32, b32;
    #1;
    g  = m_busy ? -1 : pick(req_valid);
    er = (g >= 0) ? 4'(1 << g) : 4'b0;
    ev = 4'b0;
    ep = 32'b0;
    if (m_busy && cyc >= m_due) begin
      ev = 4'(1 << m_owner);
      ep = m_prod;
    end
    check("req_ready", 32'(req_ready), 32'(er));
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    check("rsp_payload", rsp_payload, ep);
    obs_rv  = rsp_valid;
    obs_pl  = rsp_payload;
    obs_cyc = cyc;
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) begin
        acc_idx.push_back(i);
        acc_cyc.push_back(cyc);
      end
    if ((rsp_valid & rsp_ready) != 4'b0) begin
      if (exp_q.size() > 0) check("sb_payload", rsp_payload, exp_q.pop_front());
      else                  check("sb_spurious", 32'd1, 32'd0);
    end
    if (m_busy) begin
      if (cyc >= m_due && rsp_ready[m_owner]) m_busy = 0;
    end else if (g >= 0) begin
      a32     = 32'(req_a[g*16 +: 16]);
      b32     = 32'(req_b[g*16 +: 16]);
      m_prod  = a32 * b32;
      m_owner = g;
      m_ptr   = (g + 1) % 4;
      m_busy  = 1;
      m_due   = cyc + LAT + 1;
      exp_q.push_back(m_prod);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_pulse();
    req_valid = 4'b0;
    reset     = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_payload", rsp_payload, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    m_busy = 0;
    m_ptr  = 0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    cyc++;
  endtask

  task automatic wait_rsp();
    int guard = 0;
    obs_rv = 4'b0;
    while (obs_rv == 4'b0 && guard < 30) begin
      tick();
      guard++;
    end
    if (obs_rv == 4'b0) check("rsp_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int guard = 0;
    req_valid = 4'b0;
    rsp_ready = 4'hF;
    while (m_busy && guard < 30) begin
      tick();
      guard++;
    end
    if (m_busy) check("drain_timeout", 32'd1, 32'd0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] held;

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0;
    rsp_ready = 4'b0;
    req_a     = '0;
    req_b     = '0;
    @(negedge clk);
    reset_pulse();

    // Round-robin pick from ptr=0 right after reset.
    req_valid = 4'b1010;
    tick();
    drain();

    // Single request: req0 3*5, latency LAT+1.
    reset_pulse();
    repeat (3) tick();
    set_op(0, 16'd3, 16'd5);
    req_valid = 4'b0001;
    rsp_ready = 4'b0;
    tick();
    req_valid = 4'b0;
    wait_rsp();
    if (acc_cyc.size() > 0) check("single_latency", 32'(obs_cyc - acc_cyc[$]), 32'(LAT + 1));
    check("single_rv", 32'(obs_rv), 32'h1);
    check("single_payload", obs_pl, 32'd15);
    drain();

    // Extreme operands on requester 2.
    set_op(2, 16'hFFFF, 16'hFFFF);
    req_valid = 4'b0100;
    rsp_ready = 4'b0;
    tick();
    req_valid = 4'b0;
    wait_rsp();
    check("max_rv", 32'(obs_rv), 32'h4);
    check("max_payload", obs_pl, 32'hFFFE0001);
    drain();
    set_op(2, 16'h0, 16'hBEEF);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0;
    rsp_ready = 4'b0;
    wait_rsp();
    check("zero_payload", obs_pl, 32'd0);
    drain();

    // Backpressure on requester 1 with wrong-index rsp_ready high.
    set_op(1, 16'(($urandom_range(1, 16'hFFFF))), 16'(($urandom_range(1, 16'hFFFF))));
    req_valid = 4'b0010;
    rsp_ready = 4'b0;
    tick();
    req_valid = 4'b1111;
    rsp_ready = 4'b1101;
    wait_rsp();
    held = obs_pl;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_rv", 32'(obs_rv), 32'h2);
      check("bp_hold_pl", obs_pl, held);
    end
    req_valid = 4'b0;
    rsp_ready = 4'b0010;
    tick();
    drain();

    // Operand change after accept.
    set_op(3, 16'd7, 16'd2);
    req_valid = 4'b1000;
    rsp_ready = 4'b0;
    tick();
    set_op(3, 16'd9, 16'd2);
    req_valid = 4'b0;
    wait_rsp();
    check("opchg_payload", obs_pl, 32'd14);
    drain();

    // Reset one cycle after accept: abort, then grant restarts at 0.
    set_op(1, 16'd11, 16'd13);
    req_valid = 4'b0010;
    tick();
    reset_pulse();
    repeat (LAT + 4) tick();
    acc_idx.delete();
    acc_cyc.delete();
    req_valid = 4'b1111;
    tick();
    check("post_rst_cnt", 32'(acc_idx.size()), 32'd1);
    if (acc_idx.size() > 0) check("post_rst_grant", 32'(acc_idx[0]), 32'd0);
    drain();

    // Contention from reset: order 0,1,2,3,0 spaced LAT+2.
    reset_pulse();
    acc_idx.delete();
    acc_cyc.delete();
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int i = 0; i < 4; i++) set_op(i, 16'($urandom), 16'($urandom));
    begin
      int guard = 0;
      while (acc_idx.size() < 5 && guard < 100) begin
        tick();
        guard++;
      end
    end
    check("cont_count", 32'(acc_idx.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < acc_idx.size()) check("cont_order", 32'(acc_idx[i]), 32'(i % 4));
      if (i >= 1 && i < acc_cyc.size())
        check("cont_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(LAT + 2));
    end
    drain();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) set_op(i, 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 7) == 0) req_valid = 4'b0;
      tick();
    end
    drain();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 The block SHALL have parameter LAT, default 2, meaning multiplier latency in cycles from operand issue to product capture, legal range 1..8.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have port reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-004 The block SHALL have port req_valid, input, 4 bits, meaning per-requester operand valid.
REQ-005 The block SHALL have port req_ready, output, 4 bits, meaning per-requester accept; at most one bit high.
REQ-006 The block SHALL have port req_a, input, 64 bits, meaning operand A, 16 bits per requester, requester i at bits [16i+15:16i].
REQ-007 The block SHALL have port req_b, input, 64 bits, meaning operand B, packed as req_a.
REQ-008 The block SHALL have port rsp_valid, output, 4 bits, meaning one-hot result valid to the owning requester.
REQ-009 The block SHALL have port rsp_ready, input, 4 bits, meaning per-requester result accept.
REQ-010 The block SHALL have port rsp_payload, output, 32 bits, meaning the unsigned product, shared by all requesters.

Function
REQ-011 The block SHALL arbitrate one shared 16x16 unsigned multiplier among 4 requesters, one operation outstanding at a time.
REQ-012 The FSM SHALL have the states IDLE, MUL and RESP.
REQ-013 In IDLE, the block SHALL assert req_ready[g] only for g, the first index with req_valid high, searching round-robin from pointer ptr upward modulo 4; req_ready SHALL be 0 when no req_valid is high.
REQ-014 On req_valid[g] and req_ready[g] in the same cycle, the block SHALL latch A, B and g, set ptr to (g+1) mod 4, load the cycle counter with LAT, and enter MUL.
REQ-015 In MUL, req_ready SHALL be all zero and the counter SHALL decrement each cycle; on the cycle it reaches 0, the block SHALL capture the 32-bit product and enter RESP.
REQ-016 In RESP, rsp_valid SHALL equal one-hot(g), and rsp_payload SHALL hold the product stable until rsp_ready[g] is high.
REQ-017 On the RESP handshake, the block SHALL return to IDLE; no new request SHALL be accepted in the handshake cycle.
REQ-018 rsp_ready bits other than g SHALL be ignored.
REQ-019 Outside RESP, rsp_valid SHALL be 0 and rsp_payload SHALL be 0.
REQ-020 Latency SHALL be: accept in cycle N gives rsp_valid in cycle N+LAT+1; minimum spacing between accepts SHALL be LAT+2 cycles.
REQ-021 The product SHALL be full-width unsigned with no truncation; 0xFFFF*0xFFFF SHALL give 0xFFFE0001.
REQ-022 Requester operands SHALL be sampled only in the accept cycle; later changes SHALL have no effect.
REQ-023 A requester dropping req_valid before being granted SHALL lose nothing; there SHALL be no grant latching across cycles in IDLE.
REQ-024 Fairness: under continuous requests from all requesters, grants SHALL follow the order 0,1,2,3,0,… with no requester starved.

Reset
REQ-025 Reset SHALL put the FSM in IDLE, set ptr=0 and counter=0, and clear the latched operands and product to 0.
REQ-026 After reset, rsp_valid SHALL be 0 and rsp_payload SHALL be 0; req_ready SHALL follow REQ-013.
REQ-027 Reset asserted in MUL or RESP SHALL abort the operation silently, with no rsp_valid afterwards for that operation.

Structure
REQ-028 Package mul_share_pkg SHALL hold NREQ=4, OP_W=16, RES_W=32 and the FSM state enum.
REQ-029 The multiplier SHALL be a separate sub-module mul_core (registered, LAT stages, start/done pulses), instantiated once.
REQ-030 The round-robin priority select SHALL be a function within the arbiter, not a separate module.

Verification
REQ-031 Single request: req0 A=3, B=5 with LAT=2, accepted at cycle 10 -> rsp_valid=0001 at cycle 13 with payload 15.
REQ-032 Extreme values: req2 A=0xFFFF, B=0xFFFF -> payload 0xFFFE0001 on rsp_valid=0100; A=0 gives 0.
REQ-033 Contention: all four requesters valid continuously from reset -> grant order 0,1,2,3,0, with accepts spaced exactly LAT+2 cycles apart.
REQ-034 Backpressure: rsp_ready[1] held low for 5 cycles in RESP -> rsp_valid and payload held stable for 5 cycles, req_ready stays 0, and wrong-index rsp_ready is ignored.
REQ-035 Reset mid-MUL: reset pulsed 1 cycle after accept -> no rsp_valid appears, and the next request is granted from ptr=0.
REQ-036 Operand change after accept: A changed from 7 to 9 the cycle after accept with B=2 -> payload 14.
